// File: rtl/hilo_pkg.sv
// hilo_pkg: op/state encodings and timeout default for the HI/LO controller.
// HILO_MADD_EN makes op 7 (MADD) a multiply-accumulate.
package hilo_pkg;
   typedef enum logic [2:0] {
      HILO_OP_NOP   = 3'd0,
      HILO_OP_MULT  = 3'd1,
      HILO_OP_MULTU = 3'd2,
      HILO_OP_MTHI  = 3'd3,
      HILO_OP_MTLO  = 3'd4,
      HILO_OP_MFHI  = 3'd5,
      HILO_OP_MFLO  = 3'd6,
      HILO_OP_MADD  = 3'd7
   } hilo_op_e;

   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_WRITE} hilo_state_e;

   localparam int MUL_TIMEOUT_DEF = 8;

   function automatic logic is_mul_op(input logic [2:0] op);
`ifdef HILO_MADD_EN
      return op == HILO_OP_MULT || op == HILO_OP_MULTU || op == HILO_OP_MADD;
`else
      return op == HILO_OP_MULT || op == HILO_OP_MULTU;
`endif
   endfunction
endpackage

// File: rtl/hilo_regfile.sv
// hilo_regfile: architectural HI/LO registers with an MT write port and a 64-bit product port.
// HILO_MADD_EN adds the accumulate adder on the product port.
module hilo_regfile (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mt_hi_we,
   input  logic        mt_lo_we,
   input  logic [31:0] mt_data,
   input  logic        wr_en,
   input  logic        acc,
   input  logic [63:0] wr_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   logic [63:0] wr_val;
`ifdef HILO_MADD_EN
   assign wr_val = acc ? {hi, lo} + wr_data : wr_data;
`else
   logic unused_acc;
   assign unused_acc = acc;
   assign wr_val = wr_data;
`endif
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         hi <= '0;
         lo <= '0;
      end else if (wr_en) begin
         {hi, lo} <= wr_val;
      end else begin
         if (mt_hi_we) hi <= mt_data;
         if (mt_lo_we) lo <= mt_data;
      end
endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: EX-stage HI/LO controller driving the multi-cycle multiplier.
// HILO_MADD_EN enables MADD (op 7) with accumulate into {hi,lo}.
module hilo_ctrl
   import hilo_pkg::*;
#(
   parameter int MUL_TIMEOUT = MUL_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   input  logic [2:0]  ex_op,
   input  logic [31:0] ex_src_a,
   input  logic [31:0] ex_src_b,
   input  logic        ex_flush,
   output logic        ex_stall,
   output logic [31:0] rd_data,
   output logic        mul_en,
   output logic        mul_signed,
   output logic [31:0] mul_x,
   output logic [31:0] mul_y,
   input  logic        mul_complete,
   input  logic [63:0] mul_result,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        mul_err
);
   localparam int CW = $clog2(MUL_TIMEOUT + 1);

   hilo_state_e state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [63:0] prod_q;
   logic cancel_q, retire_q, acc_q;
   logic idle, start, timeout, cancel_now, wr_en, mt_hi_we, mt_lo_we;

   assign idle       = state_q == ST_IDLE;
   // retire_q blocks relaunching the multiply that is still held in EX on its retire cycle
   assign start      = idle && ex_valid && !ex_flush && !retire_q && is_mul_op(ex_op);
   assign timeout    = state_q == ST_WAIT && !mul_complete && cnt_q == CW'(MUL_TIMEOUT - 1);
   assign cancel_now = cancel_q || ex_flush;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;

   always_comb
      state_d = idle                    ? (start ? ST_LAUNCH : ST_IDLE) :
                state_q == ST_LAUNCH    ? ST_WAIT :
                state_q == ST_WAIT      ? (mul_complete ? ST_WRITE : timeout ? ST_IDLE : ST_WAIT) :
                                          ST_IDLE;

   always_comb begin
      ex_stall = start || !idle;
      mul_en   = state_q == ST_LAUNCH;
      rd_data  = ex_op == HILO_OP_MFLO ? lo : hi;
      wr_en    = state_q == ST_WRITE && !cancel_now;
      mt_hi_we = idle && ex_valid && !ex_flush && ex_op == HILO_OP_MTHI;
      mt_lo_we = idle && ex_valid && !ex_flush && ex_op == HILO_OP_MTLO;
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         mul_x      <= '0;
         mul_y      <= '0;
         mul_signed <= 1'b0;
         acc_q      <= 1'b0;
         cnt_q      <= '0;
         prod_q     <= '0;
         cancel_q   <= 1'b0;
         retire_q   <= 1'b0;
         mul_err    <= 1'b0;
      end else begin
         if (start) begin
            mul_x      <= ex_src_a;
            mul_y      <= ex_src_b;
            mul_signed <= ex_op != HILO_OP_MULTU;
            acc_q      <= ex_op == HILO_OP_MADD;
         end
         cnt_q    <= state_q == ST_LAUNCH ? '0 : state_q == ST_WAIT ? cnt_q + 1'b1 : cnt_q;
         if (state_q == ST_WAIT && mul_complete) prod_q <= mul_result;
         cancel_q <= state_d == ST_IDLE ? 1'b0 : (!idle && ex_flush) ? 1'b1 : cancel_q;
         retire_q <= !idle && state_d == ST_IDLE && !cancel_now;
         if (timeout) mul_err <= 1'b1;
      end

   hilo_regfile u_regfile (
      .clk      (clk),
      .resetn   (resetn),
      .mt_hi_we (mt_hi_we),
      .mt_lo_we (mt_lo_we),
      .mt_data  (ex_src_a),
      .wr_en    (wr_en),
      .acc      (acc_q),
      .wr_data  (prod_q),
      .hi       (hi),
      .lo       (lo)
   );
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed self-checking bench for hilo_ctrl.
// Define HILO_MADD_EN on both bench and RTL to check the MADD path.
module tb_hilo_ctrl;
   logic        clk = 0, resetn = 0;
   logic        ex_valid = 0, ex_flush = 0, mul_complete = 0;
   logic [2:0]  ex_op = 0;
   logic [31:0] ex_src_a = 0, ex_src_b = 0;
   logic [63:0] mul_result = 0;
   logic        ex_stall, mul_en, mul_signed, mul_err;
   logic [31:0] rd_data, mul_x, mul_y, hi, lo;
   int errors = 0, checks = 0;

   hilo_ctrl #(.MUL_TIMEOUT(8)) dut (
      .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_op(ex_op),
      .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_flush(ex_flush),
      .ex_stall(ex_stall), .rd_data(rd_data), .mul_en(mul_en),
      .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y),
      .mul_complete(mul_complete), .mul_result(mul_result),
      .hi(hi), .lo(lo), .mul_err(mul_err)
   );

   always #5 clk = ~clk;

   // Drives one multiply-class instruction; a small multiplier model answers lat cycles
   // after mul_en (lat=0: never). flush_k>=0 flushes k cycles after mul_en.
   task automatic do_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int flush_k, output int stalls, output int ens);
      int k;
      logic [63:0] mprod;
      stalls = 0; ens = 0; k = -1; mprod = '0;
      @(negedge clk);
      ex_valid = 1; ex_op = op; ex_src_a = a; ex_src_b = b;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!ex_stall) break;
         stalls++;
         if (mul_en) begin
            ens++;
            k = 0;
            if (mul_signed)
               mprod = $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});
            else
               mprod = {32'b0, mul_x} * {32'b0, mul_y};
         end else if (k >= 0) k++;
         mul_complete = lat > 0 && k == lat - 1;
         mul_result   = mprod;
         ex_flush     = flush_k >= 0 && k == flush_k;
         if (ex_flush) ex_valid = 0;
         @(negedge clk);
         mul_complete = 0; ex_flush = 0;
      end
      @(negedge clk);
      ex_valid = 0; ex_op = 0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
      checks++; if ({ex_stall, mul_en, mul_signed, mul_err} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b want 0000", {ex_stall, mul_en, mul_signed, mul_err}); end
      checks++; if ({mul_x, mul_y} !== 64'h0) begin errors++; $display("FAIL reset_ops: got %h want 0", {mul_x, mul_y}); end
      @(negedge clk); resetn = 1;
   endtask

   task automatic test_mult();
      int s, e;
      do_mul(3'd1, 32'hFFFFFFFE, 32'h00000003, 3, -1, s, e);
      checks++; if (s !== 5) begin errors++; $display("FAIL mult_stall: got %0d want 5", s); end
      checks++; if (e !== 1) begin errors++; $display("FAIL mult_en_pulses: got %0d want 1", e); end
      checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL mult_hilo: got %h want FFFFFFFFFFFFFFFA", {hi, lo}); end
      checks++; if ({mul_signed, mul_x, mul_y} !== {1'b1, 32'hFFFFFFFE, 32'h3}) begin errors++; $display("FAIL mult_ops: got %b %h %h want 1 fffffffe 00000003", mul_signed, mul_x, mul_y); end
   endtask

   task automatic test_multu();
      int s, e;
      do_mul(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, -1, s, e);
      checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_hilo: got %h want FFFFFFFE00000001", {hi, lo}); end
      checks++; if (mul_signed !== 1'b0) begin errors++; $display("FAIL multu_signed: got %b want 0", mul_signed); end
      checks++; if (e !== 1) begin errors++; $display("FAIL multu_en_pulses: got %0d want 1", e); end
   endtask

   task automatic test_mt_mf();
      @(negedge clk); ex_valid = 1; ex_op = 3'd3; ex_src_a = 32'h12345678;
      #1;
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b want 0", ex_stall); end
      @(negedge clk); ex_op = 3'd5; ex_src_a = 0;
      #1;
      checks++; if (rd_data !== 32'h12345678) begin errors++; $display("FAIL mfhi_data: got %h want 12345678", rd_data); end
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL mfhi_stall: got %b want 0", ex_stall); end
      @(negedge clk); ex_op = 3'd4; ex_src_a = 32'h9ABCDEF0;
      @(negedge clk); ex_op = 3'd6; ex_src_a = 0;
      #1;
      checks++; if (rd_data !== 32'h9ABCDEF0) begin errors++; $display("FAIL mflo_data: got %h want 9abcdef0", rd_data); end
      @(negedge clk); ex_op = 3'd3; ex_src_a = 32'hDEADBEEF; ex_flush = 1;
      @(negedge clk); ex_valid = 0; ex_flush = 0; ex_op = 0;
      #1;
      checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL flushed_mthi: got %h want 12345678", hi); end
   endtask

   task automatic test_flush_wait();
      int s, e;
      do_mul(3'd1, 32'd7, 32'd6, 3, 1, s, e);
      checks++; if ({hi, lo} !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL flush_hilo: got %h want 123456789ABCDEF0", {hi, lo}); end
      checks++; if (mul_err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b want 0", mul_err); end
      checks++; if ({ex_stall, mul_en} !== 2'b00 || s !== 5) begin errors++; $display("FAIL flush_idle: got stall=%b en=%b stalls=%0d want 0 0 5", ex_stall, mul_en, s); end
   endtask

   task automatic test_spurious();
      @(negedge clk); mul_complete = 1; mul_result = 64'h11111111_22222222;
      #1;
      checks++; if ({ex_stall, mul_en} !== 2'b00) begin errors++; $display("FAIL spurious_ctl: got %b want 00", {ex_stall, mul_en}); end
      @(negedge clk); mul_complete = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if ({hi, lo} !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL spurious_hilo: got %h want 123456789ABCDEF0", {hi, lo}); end
   endtask

   task automatic test_timeout();
      int s, e;
      do_mul(3'd1, 32'd5, 32'd5, 0, -1, s, e);
      checks++; if (s !== 10) begin errors++; $display("FAIL timeout_stall: got %0d want 10", s); end
      checks++; if (mul_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", mul_err); end
      checks++; if ({hi, lo} !== 64'h12345678_9ABCDEF0) begin errors++; $display("FAIL timeout_hilo: got %h want 123456789ABCDEF0", {hi, lo}); end
   endtask

   task automatic test_madd();
      int s, e;
      @(negedge clk); ex_valid = 1; ex_op = 3'd3; ex_src_a = 32'h0;
      @(negedge clk); ex_op = 3'd4; ex_src_a = 32'hFFFFFFFF;
      @(negedge clk); ex_valid = 0; ex_op = 0;
      do_mul(3'd7, 32'd1, 32'd1, 3, -1, s, e);
`ifdef HILO_MADD_EN
      checks++; if ({hi, lo} !== 64'h00000001_00000000) begin errors++; $display("FAIL madd_hilo: got %h want 0000000100000000", {hi, lo}); end
      checks++; if (s !== 5) begin errors++; $display("FAIL madd_stall: got %0d want 5", s); end
`else
      checks++; if ({hi, lo} !== 64'h00000000_FFFFFFFF) begin errors++; $display("FAIL op7_hilo: got %h want 00000000FFFFFFFF", {hi, lo}); end
      checks++; if (s !== 0 || e !== 0) begin errors++; $display("FAIL op7_nop: got stalls=%0d ens=%0d want 0 0", s, e); end
`endif
   endtask

   task automatic test_reset_mid_wait();
      int seen;
      seen = 0;
      @(negedge clk); ex_valid = 1; ex_op = 3'd1; ex_src_a = 32'hAAAA5555; ex_src_b = 32'h3;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         #1;
         if (mul_en) seen = 1;
         @(negedge clk);
      end
      ex_valid = 0; ex_op = 0;
      @(negedge clk); #1;
      checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL midwait_busy: got %b want 1", ex_stall); end
      resetn = 0;
      #1;
      checks++; if ({ex_stall, mul_en, mul_signed, mul_err} !== 4'b0) begin errors++; $display("FAIL midwait_reset_ctl: got %b want 0000", {ex_stall, mul_en, mul_signed, mul_err}); end
      checks++; if ({hi, lo, mul_x, mul_y, rd_data} !== 160'h0) begin errors++; $display("FAIL midwait_reset_data: got %h %h %h %h %h want 0", hi, lo, mul_x, mul_y, rd_data); end
      @(negedge clk); resetn = 1;
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_mt_mf();
      test_flush_wait();
      test_spurious();
      test_timeout();
      test_madd();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- EX-stage controller between the decoded instruction and the multi-cycle multiplier.
- Launches MULT/MULTU on the multiplier and stalls EX until the multiplier signals completion.
- Captures the 64-bit product into the architectural HI/LO registers; also serves MTHI/MTLO writes and MFHI/MFLO reads.
- Only producer of HI/LO state in the core.

Parameters:
- MUL_TIMEOUT, 8: max cycles in WAIT before the error flag sets and HI/LO are left unchanged.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a valid hilo-class instruction this cycle
- ex_op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 MADD (only with the optional feature)
- ex_src_a  in  32  rs value
- ex_src_b  in  32  rt value
- ex_flush  in  1  exception/branch flush of the EX instruction
- ex_stall  out  1  hold EX/ID; combinational
- rd_data  out  32  MFHI/MFLO result; valid when ex_valid, op 5/6, ex_stall=0
- mul_en  out  1  one-cycle launch pulse to the multiplier
- mul_signed  out  1  1 for MULT/MADD
- mul_x  out  32  operand A, registered
- mul_y  out  32  operand B, registered
- mul_complete  in  1  multiplier done pulse
- mul_result  in  64  product, valid with mul_complete
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- mul_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, resetn=0) clears: state=IDLE, hi=lo=0, mul_en=0, mul_signed=0, mul_x=mul_y=0, mul_err=0. Reset mid-operation abandons the pending product.
- FSM states: IDLE, LAUNCH, WAIT, WRITE.
- IDLE:
  - ex_valid & op∈{1,2,7} & ~ex_flush: go to LAUNCH; register mul_x=ex_src_a, mul_y=ex_src_b, mul_signed=(op!=2).
  - MTHI/MTLO: write hi/lo at the clock edge; FSM stays IDLE.
  - MFHI/MFLO: rd_data=hi/lo combinationally, no stall.
- LAUNCH:
  - mul_en=1 for exactly this cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - mul_complete=1: latch mul_result into an internal 64-bit product register, go to WRITE.
  - Timeout counter reaches MUL_TIMEOUT: set mul_err, go to IDLE without writing.
- WRITE: {hi,lo} <= product (or hi/lo + product with MADD); go to IDLE.
- ex_stall=1 in LAUNCH, WAIT and WRITE, and in IDLE on a cycle that starts a multiply. The EX instruction retires on the IDLE cycle after WRITE with ex_stall=0.
- Minimum multiply occupancy: 1 (LAUNCH) + multiplier latency + 1 (WRITE).
- Flush:
  - ex_flush in IDLE suppresses every action of that cycle.
  - ex_flush in LAUNCH/WAIT/WRITE sets a cancel bit. The FSM still completes its walk so the multiplier is drained, but the WRITE does not modify hi/lo. Cancel clears on return to IDLE.
- A spurious mul_complete in IDLE/LAUNCH is ignored.
- MFHI/MFLO issued while busy: stalled, then read post-WRITE values (no stale read).
- The product is treated as exactly 64 bits; no width extension beyond that.

Optional Feature:
- Macro HILO_MADD_EN.
- Defined: op 7 (MADD, signed) is a multiply, and WRITE does {hi,lo} <= {hi,lo} + product, modulo 2^64.
- Undefined: op 7 is treated as NOP (no stall, no state change), and the adder logic is absent.

Decomposition:
- Package hilo_pkg: op encodings (HILO_OP_*), state encodings, and the default for MUL_TIMEOUT.
- Sub-module hilo_regfile: HI/LO registers, MT write port, 64-bit write port with optional accumulate adder.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003 (multiplier latency 3) -> ex_stall high 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA; mul_en pulses exactly once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MTHI 0x12345678 then MFHI the next cycle -> rd_data=0x12345678, no stall.
- MULT 7×6 with ex_flush asserted in WAIT -> hi/lo keep previous values, FSM back in IDLE, mul_err=0.
- mul_complete withheld -> mul_err=1 after MUL_TIMEOUT cycles in WAIT, stall released; resetn low mid-WAIT -> all outputs 0 immediately.
- HILO_MADD_EN: hi/lo=0x0/0xFFFFFFFF, MADD 1×1 -> hi=0x1, lo=0x0; without the macro, op 7 leaves hi/lo unchanged.
